eth_frame_receiver: RTL and testbench
=====================================

ETH_FRAME_RECEIVER -- requirements
Module: eth_frame_receiver

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 1500, meaning the largest accepted payload in bytes, legal range 1..65535.
REQ-002 SHALL have parameter FILTER_EN, default 1, meaning 1 enables destination-MAC filtering and 0 accepts every frame.
REQ-003 SHALL have parameter LOCAL_MAC, default 48'hAABBCCDDEEFF, meaning the station address with the first wire byte in bits [47:40].
REQ-004 SHALL have parameter CHECK_FCS, default 1, meaning 1 enables CRC-32 checking and 0 forces crc_err to 0.
REQ-005 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  frame byte, starting at destination MAC byte 0 and ending with FCS byte 3
- rx_valid  in  1  rx_data qualifier; gaps are allowed at any byte
- rx_last  in  1  qualified by rx_valid; marks the final FCS byte
- dst_mac  out  48  captured destination address
- src_mac  out  48  captured source address
- ethertype  out  16  captured type/length field, first byte in [15:8]
- hdr_valid  out  1  one-cycle pulse when the header is complete and accepted
- pl_data  out  8  payload byte
- pl_valid  out  1  pl_data qualifier
- pl_last  out  1  marks the final payload byte
- frame_done  out  1  one-cycle end-of-frame pulse
- payload_len  out  16  payload byte count, valid while frame_done=1
- crc_err, len_err, drop  out  1 each  status bits, valid while frame_done=1

Function
REQ-006 SHALL implement states IDLE, DST, SRC, TYPE, PAYLOAD and DROP.
- On the first rx_valid in IDLE: go to DST, with that byte counted as DST byte 0.
- DST->SRC after 6 bytes; SRC->TYPE after 6 bytes; TYPE->PAYLOAD after 2 bytes.
- Any state returns to IDLE on a byte with rx_last=1.
REQ-007 SHALL count only bytes with rx_valid=1; cycles with rx_valid=0 SHALL change no state, counter or CRC.
REQ-008 SHALL make the filter decision on DST byte 5: accept if FILTER_EN=0, dst equals LOCAL_MAC, or dst equals FF:FF:FF:FF:FF:FF; otherwise go to DROP after byte 5.
REQ-009 SHALL, for an accepted frame, pulse hdr_valid one cycle after ethertype byte 1 is accepted, with dst_mac, src_mac and ethertype stable from that cycle until the next frame's DST byte 0.
REQ-010 SHALL push each PAYLOAD-state byte into a 4-byte delay line; when a push finds the line full, the oldest byte SHALL appear on pl_data with pl_valid=1 on the next cycle.
- Net effect: the 4 FCS bytes are never emitted as payload.
REQ-011 SHALL assert pl_last with the byte emitted in response to the rx_last byte; for a frame with zero payload bytes, pl_valid never asserts.
REQ-012 SHALL compute reflected CRC-32 (polynomial 0x04C11DB7, LSB first, init 0xFFFFFFFF) over all bytes from DST byte 0 through FCS byte 3.
- crc_err=1 iff CHECK_FCS=1 and the final register value is not 0xDEBB20E3.
REQ-013 SHALL set payload_len to total frame bytes minus 18.
REQ-014 SHALL set len_err=1 when rx_last arrives before 18 bytes, or when the payload count exceeds MAX_PAYLOAD.
- Payload overflow: go to DROP immediately with no further pl_valid; pl_last is never asserted for that frame.
- Short frame: payload_len=0.
REQ-015 SHALL pulse frame_done one cycle after the rx_last byte for every frame, including dropped and errored frames; drop=1 iff the frame was filtered out.
REQ-016 SHALL hold pl_valid, pl_last, hdr_valid and frame_done low in every cycle other than those specified above.
REQ-017 SHALL accept DST byte 0 of the next frame in the cycle immediately after rx_last, with no idle cycle required.
REQ-018 SHALL ignore rx_last when rx_valid=0.

Reset
REQ-019 SHALL, while rst=0, asynchronously enter IDLE, clear the delay line and counters, load the CRC register with 0xFFFFFFFF, and drive every output to 0.
REQ-020 SHALL, on reset mid-frame, emit no frame_done for the aborted frame and treat the first rx_valid after release as DST byte 0.

Verification
REQ-021 SHALL pass: dst AA:BB:CC:DD:EE:FF, src 11:22:33:44:55:66, type 0x0800, payload DE AD BE EF 12 34 56 78 9A BC, correct FCS -> hdr_valid once, 10 pl_valid bytes in order with pl_last on 0xBC, frame_done with payload_len=10 and crc_err=len_err=drop=0.
REQ-022 SHALL pass: same frame with the FCS last byte XOR 0x01 -> identical payload output, frame_done with crc_err=1.
REQ-023 SHALL pass: dst 01:02:03:04:05:06 with FILTER_EN=1 -> no hdr_valid and no pl_valid, frame_done with drop=1; broadcast dst -> accepted.
REQ-024 SHALL pass: a 12-byte frame with rx_last on byte 12 -> frame_done with len_err=1 and payload_len=0; then a back-to-back valid frame is received correctly.
REQ-025 SHALL pass: with MAX_PAYLOAD=8, the 10-byte payload frame -> exactly 8 pl_valid bytes and no pl_last, then frame_done with len_err=1.
REQ-026 SHALL pass: the REQ-021 frame with rx_valid deasserted on random cycles and rst pulsed low mid-frame once -> no output for the aborted frame, and the retransmitted frame matches REQ-021.

Source files
------------

// File: rtl/eth_frame_receiver.sv
// eth_frame_receiver: parses a byte-serial Ethernet frame (DST MAC .. FCS).
// Captures the header, filters on destination MAC and streams the payload
// through a 4-byte delay line so the FCS is never emitted. It also checks
// the reflected CRC-32 and reports per-frame status on frame_done.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   rx_data/rx_valid/rx_last input byte stream, rx_last marks FCS byte 3
//   dst_mac/src_mac/ethertype captured header fields
//   hdr_valid                pulse when an accepted header is complete
//   pl_data/pl_valid/pl_last payload byte stream
//   frame_done               end-of-frame pulse; payload_len, crc_err,
//                            len_err and drop are valid with it
module eth_frame_receiver #(
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter bit          FILTER_EN   = 1'b1,
    parameter logic [47:0] LOCAL_MAC   = 48'hAABBCCDDEEFF,
    parameter bit          CHECK_FCS   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        rx_last,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic [7:0]  pl_data,
    output logic        pl_valid,
    output logic        pl_last,
    output logic        frame_done,
    output logic [15:0] payload_len,
    output logic        crc_err,
    output logic        len_err,
    output logic        drop
);

    localparam int unsigned CNT_W    = 32;
    localparam int unsigned EMIT_W   = 17;
    localparam int unsigned DL_DEPTH = 4;
    localparam int unsigned HDR_LEN  = 18;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [31:0] CRC_POLY_R  = 32'hEDB8_8320;
    localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        DST,
        SRC,
        TYPE,
        PAYLOAD,
        DROP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   idx_q;        // bytes already received in this frame
    logic [EMIT_W-1:0]  emit_cnt_q;   // payload bytes emitted so far
    logic [2:0]         fill_q;       // delay line occupancy, saturates at 4
    logic [7:0]         dl_q [DL_DEPTH];
    logic [31:0]        crc_q;
    logic [31:0]        crc_next;
    logic               reject_q;

    logic               dst_ok_c;
    logic               reject_now_c;
    logic               hdr_fire_c;
    logic               emit_fire_c;
    logic               done_fire_c;
    logic [CNT_W-1:0]   total_c;

    // One byte of LSB-first CRC-32 update
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int b = 0; b < 8; b++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
        end
        return r;
    endfunction

    assign crc_next = crc_byte(crc_q, rx_data);
    assign total_c  = idx_q + CNT_W'(1);

    // Filter uses the five captured bytes plus the incoming DST byte 5
    assign dst_ok_c = !FILTER_EN
                   || ({dst_mac[47:8], rx_data} == LOCAL_MAC)
                   || ({dst_mac[47:8], rx_data} == BCAST_MAC);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-byte event decode
    always_comb begin
        state_d      = state_q;
        hdr_fire_c   = 1'b0;
        emit_fire_c  = 1'b0;
        done_fire_c  = 1'b0;
        reject_now_c = 1'b0;
        if (rx_valid) begin
            case (state_q)
                IDLE: state_d = DST;
                DST: begin
                    if (idx_q == CNT_W'(5)) begin
                        if (dst_ok_c) begin
                            state_d = SRC;
                        end else begin
                            state_d      = DROP;
                            reject_now_c = 1'b1;
                        end
                    end
                end
                SRC: begin
                    if (idx_q == CNT_W'(11)) state_d = TYPE;
                end
                TYPE: begin
                    if (idx_q == CNT_W'(13)) begin
                        state_d    = PAYLOAD;
                        hdr_fire_c = 1'b1;
                    end
                end
                PAYLOAD: begin
                    // A push into a full line releases the oldest byte,
                    // unless that byte would exceed the payload limit
                    if (fill_q == 3'(DL_DEPTH)) begin
                        if (emit_cnt_q == EMIT_W'(MAX_PAYLOAD)) begin
                            state_d = DROP;
                        end else begin
                            emit_fire_c = 1'b1;
                        end
                    end
                end
                DROP: state_d = DROP;
                default: state_d = IDLE;
            endcase
            if (rx_last) begin
                state_d     = IDLE;
                done_fire_c = 1'b1;
            end
        end
    end

    // Datapath: header capture, delay line, CRC, counters and status
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q       <= '0;
            emit_cnt_q  <= '0;
            fill_q      <= '0;
            crc_q       <= CRC_INIT;
            reject_q    <= 1'b0;
            for (int i = 0; i < DL_DEPTH; i++) dl_q[i] <= '0;
            dst_mac     <= '0;
            src_mac     <= '0;
            ethertype   <= '0;
            hdr_valid   <= 1'b0;
            pl_data     <= '0;
            pl_valid    <= 1'b0;
            pl_last     <= 1'b0;
            frame_done  <= 1'b0;
            payload_len <= '0;
            crc_err     <= 1'b0;
            len_err     <= 1'b0;
            drop        <= 1'b0;
        end else begin
            hdr_valid  <= hdr_fire_c;
            pl_valid   <= emit_fire_c;
            pl_last    <= emit_fire_c && rx_last;
            frame_done <= done_fire_c;
            if (emit_fire_c) begin
                pl_data    <= dl_q[0];
                emit_cnt_q <= emit_cnt_q + EMIT_W'(1);
            end
            if (rx_valid) begin
                for (int i = 0; i < 6; i++) begin
                    if (idx_q == CNT_W'(i))     dst_mac[8*(5-i) +: 8] <= rx_data;
                    if (idx_q == CNT_W'(6 + i)) src_mac[8*(5-i) +: 8] <= rx_data;
                end
                if (idx_q == CNT_W'(12)) ethertype[15:8] <= rx_data;
                if (idx_q == CNT_W'(13)) ethertype[7:0]  <= rx_data;

                if (state_q == PAYLOAD) begin
                    for (int i = 0; i < DL_DEPTH - 1; i++) dl_q[i] <= dl_q[i+1];
                    dl_q[DL_DEPTH-1] <= rx_data;
                    if (fill_q != 3'(DL_DEPTH)) fill_q <= fill_q + 3'd1;
                end
                if (reject_now_c) reject_q <= 1'b1;

                if (rx_last) begin
                    idx_q       <= '0;
                    crc_q       <= CRC_INIT;
                    fill_q      <= '0;
                    emit_cnt_q  <= '0;
                    reject_q    <= 1'b0;
                    payload_len <= (total_c < CNT_W'(HDR_LEN)) ? 16'd0
                                                               : 16'(total_c - CNT_W'(HDR_LEN));
                    len_err     <= (total_c < CNT_W'(HDR_LEN))
                                || ((total_c - CNT_W'(HDR_LEN)) > CNT_W'(MAX_PAYLOAD));
                    crc_err     <= CHECK_FCS && (crc_next != CRC_RESIDUE);
                    drop        <= reject_q || reject_now_c;
                end else begin
                    idx_q <= idx_q + CNT_W'(1);
                    crc_q <= crc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_receiver.sv
// Testbench for eth_frame_receiver: two instances (default limit and an
// 8-byte payload limit) share one input stream; a frame-level model pushes
// expected headers, payload bytes and status into per-instance queues and a
// negedge monitor pops and compares whenever an instance produces output.
module tb_eth_frame_receiver;

    localparam logic [47:0] LMAC  = 48'hAABBCCDDEEFF;
    localparam logic [47:0] BCAST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] SRC0  = 48'h112233445566;
    localparam int          MAX_A = 1500;
    localparam int          MAX_B = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;

    logic [47:0] dst_mac_o     [2];
    logic [47:0] src_mac_o     [2];
    logic [15:0] ethertype_o   [2];
    logic        hdr_valid_o   [2];
    logic [7:0]  pl_data_o     [2];
    logic        pl_valid_o    [2];
    logic        pl_last_o     [2];
    logic        frame_done_o  [2];
    logic [15:0] payload_len_o [2];
    logic        crc_err_o     [2];
    logic        len_err_o     [2];
    logic        drop_o        [2];

    eth_frame_receiver #(
        .MAX_PAYLOAD(MAX_A), .FILTER_EN(1'b1), .LOCAL_MAC(LMAC), .CHECK_FCS(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
        .dst_mac(dst_mac_o[0]), .src_mac(src_mac_o[0]), .ethertype(ethertype_o[0]),
        .hdr_valid(hdr_valid_o[0]), .pl_data(pl_data_o[0]), .pl_valid(pl_valid_o[0]),
        .pl_last(pl_last_o[0]), .frame_done(frame_done_o[0]), .payload_len(payload_len_o[0]),
        .crc_err(crc_err_o[0]), .len_err(len_err_o[0]), .drop(drop_o[0])
    );

    eth_frame_receiver #(
        .MAX_PAYLOAD(MAX_B), .FILTER_EN(1'b1), .LOCAL_MAC(LMAC), .CHECK_FCS(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last),
        .dst_mac(dst_mac_o[1]), .src_mac(src_mac_o[1]), .ethertype(ethertype_o[1]),
        .hdr_valid(hdr_valid_o[1]), .pl_data(pl_data_o[1]), .pl_valid(pl_valid_o[1]),
        .pl_last(pl_last_o[1]), .frame_done(frame_done_o[1]), .payload_len(payload_len_o[1]),
        .crc_err(crc_err_o[1]), .len_err(len_err_o[1]), .drop(drop_o[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // Expected responses per instance: header {dst,src,type}, payload
    // {last,data}, status {payload_len,crc_err,len_err,drop}
    logic [111:0] hq0[$], hq1[$];
    logic [8:0]   pq0[$], pq1[$];
    logic [18:0]  dq0[$], dq1[$];

    logic [7:0] fb[$];
    logic [7:0] req_pay [10] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12,
                                 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};

    task automatic chk(input string name, input int d, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] got=%0h required=%0h at %0t", name, d, got, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input int d, input logic [127:0] got);
        n_cmp++;
        n_err++;
        $display("FAIL %s[dut%0d] unexpected output got=%0h required=none at %0t",
                 name, d, got, $time);
    endtask

    // Output monitor
    always @(negedge clk) begin : monitor
        logic [127:0] e;
        for (int d = 0; d < 2; d++) begin
            if (hdr_valid_o[d]) begin
                if ((d == 0 ? hq0.size() : hq1.size()) == 0) begin
                    unexpected("hdr", d, 128'({dst_mac_o[d], src_mac_o[d], ethertype_o[d]}));
                end else begin
                    if (d == 0) e = 128'(hq0.pop_front());
                    else        e = 128'(hq1.pop_front());
                    chk("hdr", d, 128'({dst_mac_o[d], src_mac_o[d], ethertype_o[d]}), e);
                end
            end
            if (pl_valid_o[d]) begin
                if ((d == 0 ? pq0.size() : pq1.size()) == 0) begin
                    unexpected("payload", d, 128'({pl_last_o[d], pl_data_o[d]}));
                end else begin
                    if (d == 0) e = 128'(pq0.pop_front());
                    else        e = 128'(pq1.pop_front());
                    chk("payload", d, 128'({pl_last_o[d], pl_data_o[d]}), e);
                end
            end else if (pl_last_o[d]) begin
                unexpected("pl_last_without_valid", d, 128'(pl_last_o[d]));
            end
            if (frame_done_o[d]) begin
                if ((d == 0 ? dq0.size() : dq1.size()) == 0) begin
                    unexpected("done", d, 128'({payload_len_o[d], crc_err_o[d],
                                                len_err_o[d], drop_o[d]}));
                end else begin
                    if (d == 0) e = 128'(dq0.pop_front());
                    else        e = 128'(dq1.pop_front());
                    chk("done", d, 128'({payload_len_o[d], crc_err_o[d],
                                         len_err_o[d], drop_o[d]}), e);
                end
            end
        end
    end

    // Ethernet FCS over the first cnt bytes: bitwise LSB-first CRC, inverted
    function automatic logic [31:0] crc_of(input int cnt);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < cnt; i++) begin
            for (int b = 0; b < 8; b++) begin
                if (c[0] ^ fb[i][b]) c = (c >> 1) ^ 32'hEDB8_8320;
                else                 c = c >> 1;
            end
        end
        return ~c;
    endfunction

    task automatic build(input logic [47:0] dst, input logic [47:0] src,
                         input logic [15:0] typ, input int plen,
                         input bit fixed_pay, input bit corrupt);
        logic [31:0] f;
        logic [7:0]  b;
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(dst[8*(5-i) +: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(src[8*(5-i) +: 8]);
        fb.push_back(typ[15:8]);
        fb.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++) fb.push_back(fixed_pay ? req_pay[i] : 8'($urandom));
        f = crc_of(fb.size());
        for (int i = 0; i < 4; i++) fb.push_back(f[8*i +: 8]);
        if (corrupt) begin
            b = fb.pop_back();
            fb.push_back(b ^ 8'h01);
        end
    endtask

    // Frame-level reference: what one instance with payload limit m must emit
    task automatic expect_cfg(input int d, input int m);
        int          n;
        int          pl;
        int          ne;
        bit          acc;
        logic [47:0] dst;
        logic [47:0] src;
        logic [31:0] fcs;
        logic [18:0] st;
        n   = fb.size();
        dst = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
        acc = (dst == LMAC) || (dst == BCAST);
        if (acc && n >= 14) begin
            src = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
            if (d == 0) hq0.push_back({dst, src, fb[12], fb[13]});
            else        hq1.push_back({dst, src, fb[12], fb[13]});
        end
        pl = (n >= 18) ? n - 18 : 0;
        if (acc) begin
            ne = (pl > m) ? m : pl;
            for (int k = 0; k < ne; k++) begin
                if (d == 0) pq0.push_back({(pl <= m) && (k == ne - 1), fb[14 + k]});
                else        pq1.push_back({(pl <= m) && (k == ne - 1), fb[14 + k]});
            end
        end
        fcs = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
        st  = {16'(pl), crc_of(n - 4) != fcs, (n < 18) || (pl > m), !acc};
        if (d == 0) dq0.push_back(st);
        else        dq1.push_back(st);
    endtask

    task automatic expect_frame();
        expect_cfg(0, MAX_A);
        expect_cfg(1, MAX_B);
    endtask

    task automatic idle_cycle();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        rx_last  = 1'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit last);
        rx_valid = 1'b1;
        rx_data  = b;
        rx_last  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_check();
        for (int d = 0; d < 2; d++) begin
            chk("reset_hdr_fields", d, 128'({dst_mac_o[d], src_mac_o[d], ethertype_o[d]}), '0);
            chk("reset_flags", d, 128'({hdr_valid_o[d], pl_data_o[d], pl_valid_o[d],
                                        pl_last_o[d], frame_done_o[d], payload_len_o[d],
                                        crc_err_o[d], len_err_o[d], drop_o[d]}), '0);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rst      = 1'b0;
        #1;
        reset_check();
        repeat (2) @(posedge clk);
        #1;
        reset_check();
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Drives fb with random gaps; abort_at >= 0 resets before that byte
    task automatic drive_frame(input int gap_pct, input int abort_at);
        for (int i = 0; i < fb.size(); i++) begin
            if (i == abort_at) begin
                do_reset();
                return;
            end
            while (int'($urandom_range(0, 99)) < gap_pct) idle_cycle();
            drive_byte(fb[i], i == fb.size() - 1);
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    initial begin
        int          sel;
        int          plen;
        int          trunc;
        logic [47:0] dst;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_data  = 8'h00;
        #2;
        do_reset();

        // Reference frame, then the same with a bad FCS
        build(LMAC, SRC0, 16'h0800, 10, 1'b1, 1'b0);
        expect_frame();
        drive_frame(0, -1);
        build(LMAC, SRC0, 16'h0800, 10, 1'b1, 1'b1);
        expect_frame();
        drive_frame(0, -1);

        // Filtered unicast, then accepted broadcast
        build(48'h010203040506, SRC0, 16'h0800, 10, 1'b1, 1'b0);
        expect_frame();
        drive_frame(0, -1);
        build(BCAST, SRC0, 16'h0800, 10, 1'b1, 1'b0);
        expect_frame();
        drive_frame(0, -1);

        // 12-byte runt immediately followed by a good frame
        build(LMAC, SRC0, 16'h0800, 10, 1'b1, 1'b0);
        while (fb.size() > 12) void'(fb.pop_back());
        expect_frame();
        drive_frame(0, -1);
        build(LMAC, SRC0, 16'h0800, 10, 1'b1, 1'b0);
        expect_frame();
        drive_frame(0, -1);

        // Gappy frame aborted by reset, then retransmitted with gaps
        build(LMAC, SRC0, 16'h0800, 10, 1'b1, 1'b0);
        drive_frame(30, 8);
        expect_frame();
        drive_frame(30, -1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            sel = int'($urandom_range(0, 2));
            dst = (sel == 0) ? LMAC : (sel == 1) ? BCAST : {$urandom, 16'($urandom)};
            plen = int'($urandom_range(0, 14));
            build(dst, {$urandom, 16'($urandom)}, 16'($urandom), plen, 1'b0,
                  $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) begin
                trunc = int'($urandom_range(6, 17));
                while (fb.size() > trunc) void'(fb.pop_back());
            end
            expect_frame();
            drive_frame(int'($urandom_range(0, 40)), -1);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end

        repeat (20) idle_cycle();
        chk("leftover_hdr", 0, 128'(hq0.size()), '0);
        chk("leftover_hdr", 1, 128'(hq1.size()), '0);
        chk("leftover_payload", 0, 128'(pq0.size()), '0);
        chk("leftover_payload", 1, 128'(pq1.size()), '0);
        chk("leftover_done", 0, 128'(dq0.size()), '0);
        chk("leftover_done", 1, 128'(dq1.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
